// File: rtl/serial_feeder.sv
// Parallel-to-serial frame feeder: accepts a WIDTH-bit frame, emits one bit every DIV
// enabled cycles with a load strobe, then pulses frame_done before accepting the next frame.
module serial_feeder #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             msb_first,
    input  logic             en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done,
    output logic [1:0]       state_dbg
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    // Handshake: a frame transfers on a rising edge where din_valid and din_ready are both 1;
    // din_ready is high only in IDLE, so din is never sampled while a frame is in flight.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             msb_lat;
    logic [BCW-1:0]   bit_cnt;
    logic [DCW-1:0]   div_cnt;

    assign bit_valid = (state == SHIFT) && en && (div_cnt == DIV_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            msb_lat    <= 1'b0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            din_ready  <= 1'b1;
            bit_out    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        state     <= SHIFT;
                        shreg     <= din;
                        msb_lat   <= msb_first;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        din_ready <= 1'b0;
                        busy      <= 1'b1;
                        bit_out   <= msb_first ? din[WIDTH-1] : din[0];
                    end
                end
                SHIFT: begin
                    if (en) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            if (bit_cnt == BIT_LAST) begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                                bit_out    <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                // bit_out is registered, so preload the bit that moves into the output slot
                                if (msb_lat) begin
                                    shreg   <= shreg << 1;
                                    bit_out <= shreg[WIDTH-2];
                                end else begin
                                    shreg   <= shreg >> 1;
                                    bit_out <= shreg[1];
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    din_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    din_ready  <= 1'b1;
                    bit_out    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_feeder.sv
// Bench for serial_feeder: a DIV=4 and a DIV=1 instance, each checked every cycle
// against a frame-level model, plus directed frames with literal expectations.
module tb_serial_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // DUT A: WIDTH=8, DIV=4
    logic       reset_a = 1'b0, din_valid_a = 1'b0, msb_a = 1'b1, en_a = 1'b1;
    logic [7:0] din_a = 8'h00;
    logic       din_ready_a, bit_out_a, bit_valid_a, busy_a, frame_done_a;
    logic [1:0] state_a;

    serial_feeder #(.WIDTH(8), .DIV(4)) u_a (
        .clk(clk), .reset(reset_a), .din(din_a), .din_valid(din_valid_a),
        .din_ready(din_ready_a), .msb_first(msb_a), .en(en_a), .bit_out(bit_out_a),
        .bit_valid(bit_valid_a), .busy(busy_a), .frame_done(frame_done_a), .state_dbg(state_a)
    );

    // DUT B: WIDTH=8, DIV=1
    logic       reset_b = 1'b0, din_valid_b = 1'b0, msb_b = 1'b1, en_b = 1'b1;
    logic [7:0] din_b = 8'h00;
    logic       din_ready_b, bit_out_b, bit_valid_b, busy_b, frame_done_b;
    logic [1:0] state_b;

    serial_feeder #(.WIDTH(8), .DIV(1)) u_b (
        .clk(clk), .reset(reset_b), .din(din_b), .din_valid(din_valid_b),
        .din_ready(din_ready_b), .msb_first(msb_b), .en(en_b), .bit_out(bit_out_b),
        .bit_valid(bit_valid_b), .busy(busy_b), .frame_done(frame_done_b), .state_dbg(state_b)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: k counts enabled SHIFT cycles since accept; bit index is k/div.
    typedef struct {
        int         mode;   // 0 waiting, 1 sending, 2 finished
        logic [7:0] frame;
        logic       msb;
        int         k;
    } mdl_t;

    function automatic logic [4:0] mdl_out(mdl_t m, logic en, int div);
        int   idx;
        logic b;
        idx = m.k / div;
        b = 1'b0;
        if (m.mode == 1) b = m.msb ? m.frame[7 - idx] : m.frame[idx];
        return {m.mode == 0, m.mode != 0, m.mode == 2, b,
                (m.mode == 1) && en && (m.k % div == div - 1)};
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, logic rst_n, logic dv, logic [7:0] d,
                                      logic msb, logic en, int div);
        mdl_t n;
        n = m;
        if (!rst_n) begin
            n.mode = 0;
            n.k = 0;
        end else begin
            case (m.mode)
                0: if (dv) begin
                    n.mode = 1; n.frame = d; n.msb = msb; n.k = 0;
                end
                1: if (en) begin
                    n.k = m.k + 1;
                    if (n.k == 8 * div) n.mode = 2;
                end
                default: n.mode = 0;
            endcase
        end
        return n;
    endfunction

    bit   check_on = 1'b0;
    mdl_t ma = '{mode: 0, frame: 8'h00, msb: 1'b0, k: 0};
    mdl_t mb = '{mode: 0, frame: 8'h00, msb: 1'b0, k: 0};

    // Output vector order: {din_ready, busy, frame_done, bit_out, bit_valid}
    always @(negedge clk) begin
        if (check_on) begin
            check("a_outputs", {27'd0, din_ready_a, busy_a, frame_done_a, bit_out_a, bit_valid_a},
                  {27'd0, mdl_out(ma, en_a, 4)});
            ma = mdl_next(ma, reset_a, din_valid_a, din_a, msb_a, en_a, 4);
            check("b_outputs", {27'd0, din_ready_b, busy_b, frame_done_b, bit_out_b, bit_valid_b},
                  {27'd0, mdl_out(mb, en_b, 1)});
            mb = mdl_next(mb, reset_b, din_valid_b, din_b, msb_b, en_b, 1);
        end
    end

    // Frame capture monitors feeding the directed literal checks
    logic [7:0] cap_a = 0, last_cap_a = 0;
    int strobes_a = 0, last_strobes_a = 0, done_cnt_a = 0, acc_cyc_a = 0;
    int last_span_a = 0, last_done_cyc_a = 0;

    always @(negedge clk) begin
        if (reset_a && din_valid_a && din_ready_a) begin
            acc_cyc_a = cyc; cap_a = 0; strobes_a = 0;
        end
        if (bit_valid_a) begin
            cap_a = {cap_a[6:0], bit_out_a}; strobes_a++;
        end
        if (frame_done_a) begin
            done_cnt_a++; last_cap_a = cap_a; last_strobes_a = strobes_a;
            last_span_a = cyc - acc_cyc_a + 1; last_done_cyc_a = cyc;
        end
    end

    logic [7:0] cap_b = 0, last_cap_b = 0;
    int strobes_b = 0, last_strobes_b = 0, done_cnt_b = 0, acc_cyc_b = 0;
    int last_span_b = 0, first_strobe_b = 0, last_strobe_b = 0;

    always @(negedge clk) begin
        if (reset_b && din_valid_b && din_ready_b) begin
            acc_cyc_b = cyc; cap_b = 0; strobes_b = 0;
        end
        if (bit_valid_b) begin
            if (strobes_b == 0) first_strobe_b = cyc;
            last_strobe_b = cyc;
            cap_b = {cap_b[6:0], bit_out_b}; strobes_b++;
        end
        if (frame_done_b) begin
            done_cnt_b++; last_cap_b = cap_b; last_strobes_b = strobes_b;
            last_span_b = cyc - acc_cyc_b + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic m);
        int t;
        t = 0;
        while (!din_ready_a && t < 100) begin step(); t++; end
        if (!din_ready_a) check("a_ready_timeout", 0, 1);
        din_a = d; msb_a = m; din_valid_a = 1'b1;
        step();
        din_valid_a = 1'b0;
    endtask

    task automatic wait_done_a(input int n0, input bit scramble);
        int t;
        t = 0;
        while (done_cnt_a == n0 && t < 300) begin
            step(); t++;
            if (scramble && done_cnt_a == n0) din_a = 8'($urandom);
        end
        if (done_cnt_a == n0) check("a_done_timeout", 0, 1);
    endtask

    task automatic wait_strobes_a(input int n);
        int t;
        t = 0;
        while (strobes_a < n && t < 200) begin step(); t++; end
        if (strobes_a < n) check("a_strobe_timeout", strobes_a, n);
    endtask

    initial begin
        int n, d1;
        // Reset held across the first edges
        step();
        check_on = 1'b1;
        step();
        check("a_rst_ready", din_ready_a, 1);
        check("a_rst_bit_out", bit_out_a, 0);
        check("a_rst_bit_valid", bit_valid_a, 0);
        check("a_rst_busy", busy_a, 0);
        check("a_rst_frame_done", frame_done_a, 0);
        check("b_rst_ready", din_ready_b, 1);
        reset_a = 1'b1; reset_b = 1'b1;
        step();

        // 0xB4 MSB first: 1,0,1,1,0,1,0,0; accept through DONE spans 34 cycles
        n = done_cnt_a;
        send_a(8'hB4, 1'b1);
        wait_done_a(n, 1'b0);
        check("a_b4_msb_bits", last_cap_a, 8'hB4);
        check("a_b4_msb_strobes", last_strobes_a, 8);
        check("a_b4_msb_span", last_span_a, 34);

        // 0xB4 LSB first: 0,0,1,0,1,1,0,1; msb_first flipped mid-frame has no effect
        n = done_cnt_a;
        send_a(8'hB4, 1'b0);
        repeat (10) step();
        msb_a = 1'b1;
        wait_done_a(n, 1'b0);
        check("a_b4_lsb_bits", last_cap_a, 8'h2D);
        check("a_b4_lsb_strobes", last_strobes_a, 8);

        // en low for 5 cycles at the start of bit 3
        n = done_cnt_a;
        send_a(8'hB4, 1'b1);
        wait_strobes_a(3);
        en_a = 1'b0;
        repeat (5) step();
        en_a = 1'b1;
        wait_done_a(n, 1'b0);
        check("a_pause_bits", last_cap_a, 8'hB4);
        check("a_pause_strobes", last_strobes_a, 8);
        check("a_pause_span", last_span_a, 39);

        // din_valid held high: 0xFF then 0x00 back to back, din churn during SHIFT ignored
        n = done_cnt_a;
        din_a = 8'hFF; msb_a = 1'b1; din_valid_a = 1'b1;
        step();
        din_a = 8'h00;
        wait_done_a(n, 1'b0);
        d1 = last_done_cyc_a;
        check("a_b2b_first_bits", last_cap_a, 8'hFF);
        step();
        wait_done_a(n + 1, 1'b1);
        din_valid_a = 1'b0;
        check("a_b2b_second_bits", last_cap_a, 8'h00);
        check("a_b2b_accept_gap", acc_cyc_a - d1, 1);

        // Reset pulse during bit 5 aborts the frame
        n = done_cnt_a;
        send_a(8'h5A, 1'b1);
        wait_strobes_a(5);
        step();
        reset_a = 1'b0;
        step();
        reset_a = 1'b1;
        check("a_abort_ready", din_ready_a, 1);
        check("a_abort_busy", busy_a, 0);
        repeat (40) step();
        check("a_abort_no_done", done_cnt_a, n);
        check("a_abort_no_strobes", strobes_a, 5);

        // DIV=1, 0xA5 MSB first: 8 consecutive strobes 1,0,1,0,0,1,0,1
        n = done_cnt_b;
        din_b = 8'hA5; msb_b = 1'b1; din_valid_b = 1'b1;
        step();
        din_valid_b = 1'b0;
        repeat (12) step();
        check("b_a5_done", done_cnt_b, n + 1);
        check("b_a5_bits", last_cap_b, 8'hA5);
        check("b_a5_strobes", last_strobes_b, 8);
        check("b_a5_consecutive", last_strobe_b - first_strobe_b, 7);
        check("b_a5_span", last_span_b, 10);

        // Randomized traffic on both instances, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            din_a = 8'($urandom); din_valid_a = ($urandom_range(0, 3) != 0);
            msb_a = 1'($urandom); en_a = ($urandom_range(0, 3) != 0);
            reset_a = ($urandom_range(0, 199) != 0);
            din_b = 8'($urandom); din_valid_b = ($urandom_range(0, 3) != 0);
            msb_b = 1'($urandom); en_b = ($urandom_range(0, 3) != 0);
            reset_b = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_a = 1'b1; reset_b = 1'b1;
        din_valid_a = 1'b0; din_valid_b = 1'b0;
        en_a = 1'b1; en_b = 1'b1;
        repeat (50) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
